// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - 32-bit constant to {rotate, imm8} immediate encoder, one rotation per clock
// Define IMM_ENCODER_PARALLEL_EN to test all 16 rotations in a single SEARCH cycle.
module imm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] value,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [11:0] shift_operand
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] value_q, value_n;
  logic        found_n;
  logic [11:0] shift_operand_n;

  // Circular left rotate by 2*r; a shift of 32 yields zero, so r=0 passes v through.
  function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
    logic [4:0] amt;
    amt = {r, 1'b0};
    return (v << amt) | (v >> (6'd32 - {1'b0, amt}));
  endfunction

`ifdef IMM_ENCODER_PARALLEL_EN
  logic        hit_any;
  logic [11:0] hit_operand;

  // Scan from the top down so the lowest matching rotate is the one left standing.
  always_comb begin
    logic [31:0] c;
    hit_any     = 1'b0;
    hit_operand = 12'h000;
    c           = 32'h0;
    for (int r = 15; r >= 0; r--) begin
      c = rol2(value_q, 4'(r));
      if (c[31:8] == 24'h0) begin
        hit_any     = 1'b1;
        hit_operand = {4'(r), c[7:0]};
      end
    end
  end
`else
  logic [3:0]  rot, rot_n;
  logic [31:0] cand;

  assign cand = rol2(value_q, rot);
`endif

  always_comb begin
    state_n         = state;
    value_n         = value_q;
    found_n         = found;
    shift_operand_n = shift_operand;
`ifndef IMM_ENCODER_PARALLEL_EN
    rot_n           = rot;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          value_n         = value;
          found_n         = 1'b0;
          shift_operand_n = 12'h000;
`ifndef IMM_ENCODER_PARALLEL_EN
          rot_n           = 4'd0;
`endif
          state_n         = SEARCH;
        end
      end
      SEARCH: begin
`ifdef IMM_ENCODER_PARALLEL_EN
        found_n         = hit_any;
        shift_operand_n = hit_operand;
        state_n         = DONE;
`else
        if (cand[31:8] == 24'h0) begin
          found_n         = 1'b1;
          shift_operand_n = {rot, cand[7:0]};
          state_n         = DONE;
        end else if (rot == 4'd15) begin
          found_n         = 1'b0;
          shift_operand_n = 12'h000;
          state_n         = DONE;
        end else begin
          rot_n = rot + 4'd1;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      value_q       <= 32'h0;
      found         <= 1'b0;
      shift_operand <= 12'h000;
`ifndef IMM_ENCODER_PARALLEL_EN
      rot           <= 4'd0;
`endif
    end else begin
      state         <= state_n;
      value_q       <= value_n;
      found         <= found_n;
      shift_operand <= shift_operand_n;
`ifndef IMM_ENCODER_PARALLEL_EN
      rot           <= rot_n;
`endif
    end
  end

  assign busy = (state == SEARCH);
  assign done = (state == DONE);

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder against a decode-enumeration model
module tb_imm_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] value;
  logic        busy;
  logic        done;
  logic        found;
  logic [11:0] shift_operand;

  int n_checks = 0;
  int n_fail   = 0;

  imm_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .value         (value),
    .busy          (busy),
    .done          (done),
    .found         (found),
    .shift_operand (shift_operand)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enumerate every field the decoder could see, lowest rotate first, and keep the first decode hit.
  function automatic logic [12:0] model(input logic [31:0] v);
    logic [63:0] d;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 256; i++) begin
        d = {32'(i), 32'(i)} >> (2 * r);
        if (d[31:0] == v) return {1'b1, 4'(r), 8'(i)};
      end
    end
    return 13'h0;
  endfunction

  function automatic int exp_latency(input logic [12:0] m);
`ifdef IMM_ENCODER_PARALLEL_EN
    return 2;
`else
    return m[12] ? int'(m[11:8]) + 2 : 17;
`endif
  endfunction

  // Start an encode from IDLE; report the cycle of done and the result seen with it.
  task automatic do_encode(input logic [31:0] v, output int lat, output logic f,
                           output logic [11:0] so, output logic b1);
    @(negedge clk);
    start = 1'b1;
    value = v;
    lat = -1; f = 1'bx; so = 12'hxxx; b1 = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        value = $urandom;
        b1 = busy;
      end
      if (done) begin
        lat = k; f = found; so = shift_operand;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; value = 32'h0;
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    if (found !== 1'b0) begin n_fail++; $display("FAIL reset_found got %b want 0", found); end
    if (shift_operand !== 12'h000) begin n_fail++; $display("FAIL reset_so got %h want 000", shift_operand); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [31:0] vals [5] = '{32'h000000FF, 32'hC000003F, 32'hFF000000, 32'h00000102, 32'h00000000};
    logic [11:0] sos  [5] = '{12'h0FF, 12'h1FF, 12'h4FF, 12'h000, 12'h000};
    logic        fnd  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int          lats [5] = '{2, 3, 6, 17, 2};
    int lat, el; logic f, b1; logic [11:0] so;
    for (int i = 0; i < 5; i++) begin
      do_encode(vals[i], lat, f, so, b1);
`ifdef IMM_ENCODER_PARALLEL_EN
      el = 2;
`else
      el = lats[i];
`endif
      n_checks += 4;
      if (b1 !== 1'b1) begin n_fail++; $display("FAIL dir_busy1 v=%h got %b want 1", vals[i], b1); end
      if (lat != el) begin n_fail++; $display("FAIL dir_latency v=%h got %0d want %0d", vals[i], lat, el); end
      if (f !== fnd[i]) begin n_fail++; $display("FAIL dir_found v=%h got %b want %b", vals[i], f, fnd[i]); end
      if (so !== sos[i]) begin n_fail++; $display("FAIL dir_so v=%h got %h want %h", vals[i], so, sos[i]); end
    end
  endtask

  task automatic test_random;
    int lat; logic f, b1; logic [11:0] so; logic [31:0] v; logic [12:0] m;
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) begin
        v = 32'($urandom_range(0, 255));
        v = (v >> (2 * $urandom_range(0, 15))) | (v << (32 - 2 * $urandom_range(0, 0)));
        m = 13'($urandom_range(0, 4095));
        v = ({m[7:0], 24'h0, m[7:0]} >> 0) == 0 ? v : v;
        begin
          logic [63:0] d;
          d = {24'h0, m[7:0], 24'h0, m[7:0]} >> (2 * int'(m[11:8]));
          v = d[31:0];
        end
      end else begin
        v = $urandom;
      end
      m = model(v);
      do_encode(v, lat, f, so, b1);
      n_checks += 3;
      if (lat != exp_latency(m)) begin n_fail++; $display("FAIL rnd_latency v=%h got %0d want %0d", v, lat, exp_latency(m)); end
      if (f !== m[12]) begin n_fail++; $display("FAIL rnd_found v=%h got %b want %b", v, f, m[12]); end
      if (so !== m[11:0]) begin n_fail++; $display("FAIL rnd_so v=%h got %h want %h", v, so, m[11:0]); end
    end
  endtask

  task automatic test_hold;
    int lat; logic f, b1; logic [11:0] so;
    do_encode(32'h0003FC00, lat, f, so, b1);
    for (int k = 0; k < 3; k++) begin
      value = $urandom;
      @(negedge clk);
      n_checks += 3;
      if (done !== 1'b0) begin n_fail++; $display("FAIL hold_done k=%0d got %b want 0", k, done); end
      if (found !== 1'b1) begin n_fail++; $display("FAIL hold_found k=%0d got %b want 1", k, found); end
      if (shift_operand !== 12'hBFF) begin n_fail++; $display("FAIL hold_so k=%0d got %h want BFF", k, shift_operand); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, ign, el;
`ifdef IMM_ENCODER_PARALLEL_EN
    ign = 1; el = 2;
`else
    ign = 3; el = 10;
`endif
    @(negedge clk);
    start = 1'b1; value = 32'h00FF0000;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == ign) begin start = 1'b1; value = 32'h000000FF; end
      if (k == ign + 1) start = 1'b0;
      if (done) begin lat = k; break; end
    end
    n_checks += 3;
    if (lat != el) begin n_fail++; $display("FAIL b2b_latency got %0d want %0d", lat, el); end
    if (found !== 1'b1) begin n_fail++; $display("FAIL b2b_found got %b want 1", found); end
    if (shift_operand !== 12'h8FF) begin n_fail++; $display("FAIL b2b_so got %h want 8FF", shift_operand); end
    start = 1'b1; value = 32'h00000102;
    @(negedge clk);
    n_checks += 3;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_start_busy got %b want 0", busy); end
    if (found !== 1'b1) begin n_fail++; $display("FAIL b2b_done_start_found got %b want 1", found); end
    if (shift_operand !== 12'h8FF) begin n_fail++; $display("FAIL b2b_done_start_so got %h want 8FF", shift_operand); end
    value = 32'h000000FF;
    @(negedge clk);
    start = 1'b0;
    n_checks += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got %b want 1", busy); end
    if (found !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_found_clr got %b want 0", found); end
    if (shift_operand !== 12'h000) begin n_fail++; $display("FAIL b2b_accept_so_clr got %h want 000", shift_operand); end
    @(negedge clk);
    n_checks += 2;
    if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b want 1", done); end
    if (shift_operand !== 12'h0FF) begin n_fail++; $display("FAIL b2b_second_so got %h want 0FF", shift_operand); end
  endtask

  task automatic test_reset_mid;
    int lat; logic f, b1; logic [11:0] so; logic saw_done;
    @(negedge clk);
    start = 1'b1; value = 32'h00000102;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got %b want 0", done); end
    if (found !== 1'b0) begin n_fail++; $display("FAIL mid_rst_found got %b want 0", found); end
    if (shift_operand !== 12'h000) begin n_fail++; $display("FAIL mid_rst_so got %h want 000", shift_operand); end
    saw_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_done got %b want 0", saw_done); end
    do_encode(32'h000000FF, lat, f, so, b1);
    n_checks += 3;
    if (lat != 2) begin n_fail++; $display("FAIL post_rst_latency got %0d want 2", lat); end
    if (f !== 1'b1) begin n_fail++; $display("FAIL post_rst_found got %b want 1", f); end
    if (so !== 12'h0FF) begin n_fail++; $display("FAIL post_rst_so got %h want 0FF", so); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
